// File: rtl/forward_history_buffer.sv
// Keeps the last FORWARDED_CLOCK_CYCLES table writes and cuckoo shifts, and forwards the newest record matching
// each table's read address. Capture takes 1 cycle and lookup is combinational. There is no backpressure: clk_en freezes the history.
module forward_history_buffer #(
  parameter int DATA_WIDTH             = 4,
  parameter int KEY_WIDTH              = 2,
  parameter int NUMBER_OF_TABLES       = 3,
  parameter int FORWARDED_CLOCK_CYCLES = 2,
  parameter int MAX_HASH_ADR_WIDTH     = 2,
  parameter int HASH_TABLE_ADR_WIDTH [NUMBER_OF_TABLES] = '{2, 2, 2}
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   clk_en,
  input  logic                                                   flush_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            wr_en_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]    wr_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]             wr_key_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]            wr_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                            wr_valid_i,
  input  logic [NUMBER_OF_TABLES-2:0]                            shift_en_i,
  input  logic [NUMBER_OF_TABLES-2:0][MAX_HASH_ADR_WIDTH-1:0]    shift_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]    query_adr_i,
  output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]    forward_hash_adr_o,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]             forward_key_o,
  output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]            forward_data_o,
  output logic [NUMBER_OF_TABLES-1:0]                            forward_valid_o,
  output logic [NUMBER_OF_TABLES-1:0]                            forward_updated_mem_o,
  output logic [NUMBER_OF_TABLES-2:0][MAX_HASH_ADR_WIDTH-1:0]    forward_shift_hash_adr_o,
  output logic [NUMBER_OF_TABLES-2:0]                            forward_shift_valid_o
);
  localparam int T  = NUMBER_OF_TABLES;
  localparam int D  = FORWARDED_CLOCK_CYCLES;
  localparam int AW = MAX_HASH_ADR_WIDTH;

  typedef struct packed {
    logic                  tag;
    logic [AW-1:0]         adr;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } wr_rec_t;

  typedef struct packed {
    logic          tag;
    logic [AW-1:0] adr;
  } sh_rec_t;

  wr_rec_t wr_hist [T][D];
  sh_rec_t sh_hist [T-1][D];

  // Only the low bits a table actually decodes take part in the match.
  function automatic logic [AW-1:0] adr_mask(input int w);
    return {AW{1'b1}} >> (AW - w);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      for (int t = 0; t < T; t++)
        for (int k = 0; k < D; k++) wr_hist[t][k] <= '0;
      for (int t = 0; t < T-1; t++)
        for (int k = 0; k < D; k++) sh_hist[t][k] <= '0;
    end else if (clk_en) begin
      for (int t = 0; t < T; t++) begin
        for (int k = D-1; k > 0; k--) wr_hist[t][k] <= wr_hist[t][k-1];
        wr_hist[t][0] <= {wr_en_i[t], wr_adr_i[t], wr_key_i[t], wr_data_i[t], wr_valid_i[t]};
      end
      for (int t = 0; t < T-1; t++) begin
        for (int k = D-1; k > 0; k--) sh_hist[t][k] <= sh_hist[t][k-1];
        sh_hist[t][0] <= {shift_en_i[t], shift_adr_i[t]};
      end
    end
  end

  // Scanning oldest to newest lets the lowest-index (newest) match overwrite older ones.
  always_comb begin
    forward_hash_adr_o       = '0;
    forward_key_o            = '0;
    forward_data_o           = '0;
    forward_valid_o          = '0;
    forward_updated_mem_o    = '0;
    forward_shift_hash_adr_o = '0;
    forward_shift_valid_o    = '0;
    for (int t = 0; t < T; t++) begin
      for (int k = D-1; k >= 0; k--) begin
        if (wr_hist[t][k].tag &&
            ((wr_hist[t][k].adr ^ query_adr_i[t]) & adr_mask(HASH_TABLE_ADR_WIDTH[t])) == '0) begin
          forward_updated_mem_o[t] = 1'b1;
          forward_hash_adr_o[t]    = wr_hist[t][k].adr;
          forward_key_o[t]         = wr_hist[t][k].key;
          forward_data_o[t]        = wr_hist[t][k].data;
          forward_valid_o[t]       = wr_hist[t][k].valid;
        end
      end
    end
    for (int t = 0; t < T-1; t++) begin
      for (int k = D-1; k >= 0; k--) begin
        if (sh_hist[t][k].tag &&
            ((sh_hist[t][k].adr ^ query_adr_i[t]) & adr_mask(HASH_TABLE_ADR_WIDTH[t])) == '0) begin
          forward_shift_valid_o[t]    = 1'b1;
          forward_shift_hash_adr_o[t] = sh_hist[t][k].adr;
        end
      end
    end
  end

endmodule

// File: tb/tb_forward_history_buffer.sv
// Directed-vector bench for forward_history_buffer at the default parameters (3 tables, depth 2).
module tb_forward_history_buffer;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clk_en = 1'b0;
  logic            flush_i = 1'b0;
  logic [2:0]      wr_en_i = '0;
  logic [2:0][1:0] wr_adr_i = '0;
  logic [2:0][1:0] wr_key_i = '0;
  logic [2:0][3:0] wr_data_i = '0;
  logic [2:0]      wr_valid_i = '0;
  logic [1:0]      shift_en_i = '0;
  logic [1:0][1:0] shift_adr_i = '0;
  logic [2:0][1:0] query_adr_i = '0;
  logic [2:0][1:0] forward_hash_adr_o;
  logic [2:0][1:0] forward_key_o;
  logic [2:0][3:0] forward_data_o;
  logic [2:0]      forward_valid_o;
  logic [2:0]      forward_updated_mem_o;
  logic [1:0][1:0] forward_shift_hash_adr_o;
  logic [1:0]      forward_shift_valid_o;

  int nvec = 0;
  int nerr = 0;

  forward_history_buffer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i), .wr_key_i(wr_key_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .shift_en_i(shift_en_i), .shift_adr_i(shift_adr_i), .query_adr_i(query_adr_i),
    .forward_hash_adr_o(forward_hash_adr_o), .forward_key_o(forward_key_o),
    .forward_data_o(forward_data_o), .forward_valid_o(forward_valid_o),
    .forward_updated_mem_o(forward_updated_mem_o),
    .forward_shift_hash_adr_o(forward_shift_hash_adr_o),
    .forward_shift_valid_o(forward_shift_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({forward_hash_adr_o, forward_key_o, forward_data_o, forward_valid_o,
                forward_updated_mem_o, forward_shift_hash_adr_o, forward_shift_valid_o});
  endfunction

  task automatic put_wr(input int t, input logic [1:0] a, input logic [1:0] k,
                        input logic [3:0] d, input logic v);
    wr_en_i[t] = 1'b1; wr_adr_i[t] = a; wr_key_i[t] = k; wr_data_i[t] = d; wr_valid_i[t] = v;
  endtask

  initial begin
    // 1: reset and idle
    tick(); tick();
    reset = 1'b0;
    chk("reset_outputs", all_out(), 64'd0);
    clk_en = 1'b1;
    tick(); tick(); tick();
    chk("idle_outputs", all_out(), 64'd0);

    // 2: single write visible for exactly D cycles
    put_wr(0, 2'd1, 2'd3, 4'd3, 1'b1);
    query_adr_i[0] = 2'd1;
    tick();
    wr_en_i = '0;
    chk("wr_n1_updated", 64'(forward_updated_mem_o[0]), 64'd1);
    chk("wr_n1_key",     64'(forward_key_o[0]), 64'd3);
    chk("wr_n1_data",    64'(forward_data_o[0]), 64'd3);
    chk("wr_n1_valid",   64'(forward_valid_o[0]), 64'd1);
    chk("wr_n1_adr",     64'(forward_hash_adr_o[0]), 64'd1);
    chk("wr_n1_tbl1",    64'(forward_updated_mem_o[1]), 64'd0);
    tick();
    chk("wr_n2_updated", 64'(forward_updated_mem_o[0]), 64'd1);
    chk("wr_n2_data",    64'(forward_data_o[0]), 64'd3);
    tick();
    chk("wr_n3_aged",    64'({forward_updated_mem_o[0], forward_data_o[0]}), 64'd0);

    // 3: newest write to the same address wins
    put_wr(0, 2'd2, 2'd1, 4'd5, 1'b1);
    tick();
    put_wr(0, 2'd2, 2'd2, 4'd9, 1'b1);
    tick();
    wr_en_i = '0;
    query_adr_i[0] = 2'd2;
    #1;
    chk("newest_data", 64'(forward_data_o[0]), 64'd9);
    chk("newest_key",  64'(forward_key_o[0]), 64'd2);

    // 4: shift record plus an independent write on table 1
    shift_en_i[1] = 1'b1; shift_adr_i[1] = 2'd3;
    put_wr(1, 2'd3, 2'd0, 4'd7, 1'b1);
    tick();
    shift_en_i = '0; wr_en_i = '0;
    query_adr_i[1] = 2'd3;
    #1;
    chk("shift_valid",   64'(forward_shift_valid_o[1]), 64'd1);
    chk("shift_adr",     64'(forward_shift_hash_adr_o[1]), 64'd3);
    chk("shift_other",   64'(forward_shift_valid_o[0]), 64'd0);
    chk("shift_and_wr",  64'({forward_updated_mem_o[1], forward_data_o[1]}), 64'h17);
    query_adr_i[1] = 2'd2;
    #1;
    chk("shift_miss", 64'({forward_shift_valid_o[1], forward_shift_hash_adr_o[1]}), 64'd0);

    // 5: clk_en=0 freezes history, then flush with clk_en=0
    put_wr(2, 2'd0, 2'd1, 4'd4, 1'b1);
    query_adr_i = '0;
    tick();
    clk_en = 1'b0;
    put_wr(2, 2'd0, 2'd2, 4'd15, 1'b1);
    tick(); tick(); tick(); tick();
    chk("frozen_updated", 64'(forward_updated_mem_o[2]), 64'd1);
    chk("frozen_data",    64'(forward_data_o[2]), 64'd4);
    chk("frozen_key",     64'(forward_key_o[2]), 64'd1);
    wr_en_i = '0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_outputs", all_out(), 64'd0);

    // 6: delete record, then reset mid-history
    clk_en = 1'b1;
    put_wr(0, 2'd1, 2'd2, 4'd6, 1'b0);
    query_adr_i[0] = 2'd1;
    tick();
    wr_en_i = '0;
    chk("delete_updated", 64'(forward_updated_mem_o[0]), 64'd1);
    chk("delete_valid",   64'(forward_valid_o[0]), 64'd0);
    chk("delete_data",    64'(forward_data_o[0]), 64'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_outputs", all_out(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
